block_mult_sched: RTL and testbench

- Top-level sequencer for the tiled matrix-multiply datapath. It walks output tiles C[i][j] and, for each, the reduction index k.
- For every beat it issues row-stream read addresses for the A and B tiles.
- It generates the staggered per-row accumulator-clear pulses that the systolic array's input muxes need, waits out array drain, then streams the finished C tile to writeback over a valid/ready handshake.

---
 rtl/block_mult_sched_pkg.sv | 27 ++
 rtl/block_mult_sched_if.sv | 34 +++
 rtl/block_addr_gen.sv | 29 ++
 rtl/block_mult_sched.sv | 180 ++++++++++++++++++
 tb/tb_block_mult_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_mult_sched_pkg.sv
// Shared types, defaults and tile-row address helper for the tiled matrix-multiply sequencer.
package block_mult_sched_pkg;

    localparam int unsigned TILE_DEF   = 4;
    localparam int unsigned TILE_LOG2  = $clog2(TILE_DEF);
    localparam int unsigned NB_W_DEF   = 4;
    localparam int unsigned ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StDrain,
        StWrite,
        StFin
    } state_e;

    // Row address of row `row` inside block (blk_r, blk_c) of an nblk x nblk block grid.
    // Callers truncate the result to their address width.
    function automatic logic [31:0] tile_row_addr(input logic [31:0] blk_r,
                                                  input logic [31:0] blk_c,
                                                  input logic [31:0] nblk,
                                                  input logic [31:0] row,
                                                  input logic [31:0] tile);
        return (blk_r * nblk + blk_c) * tile + row;
    endfunction

endpackage

// File: rtl/block_mult_sched_if.sv
// A/B row-read channel and C row-writeback channel of the multiply sequencer.
interface block_mult_sched_if #(
    parameter int unsigned ADDR_W = 12
) ();

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] c_addr;

    modport master (
        output rd_valid,
        output a_addr,
        output b_addr,
        input  rd_ready,
        output out_valid,
        output c_addr,
        input  out_ready
    );

    modport slave (
        input  rd_valid,
        input  a_addr,
        input  b_addr,
        output rd_ready,
        input  out_valid,
        input  c_addr,
        output out_ready
    );

endinterface

// File: rtl/block_addr_gen.sv
// Combinational A/B/C tile-row address generation from the sequencer's loop indices.
module block_addr_gen
    import block_mult_sched_pkg::*;
#(
    parameter int unsigned TILE   = TILE_DEF,
    parameter int unsigned NB_W   = NB_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BEAT_W = TILE_LOG2
) (
    input  logic [NB_W-1:0]   i_i,
    input  logic [NB_W-1:0]   j_i,
    input  logic [NB_W-1:0]   k_i,
    input  logic [NB_W-1:0]   nblk_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [BEAT_W-1:0] row_i,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [ADDR_W-1:0] c_addr_o
);

    // A walks block row i along k, B walks block column j along k, C is block (i, j).
    assign a_addr_o = ADDR_W'(tile_row_addr(32'(i_i), 32'(k_i), 32'(nblk_i), 32'(beat_i),
                                            32'(TILE)));
    assign b_addr_o = ADDR_W'(tile_row_addr(32'(k_i), 32'(j_i), 32'(nblk_i), 32'(beat_i),
                                            32'(TILE)));
    assign c_addr_o = ADDR_W'(tile_row_addr(32'(i_i), 32'(j_i), 32'(nblk_i), 32'(row_i),
                                            32'(TILE)));

endmodule

// File: rtl/block_mult_sched.sv
// Tiled matrix-multiply sequencer: feeds A/B rows per (i, j, k), clears array accumulators,
// waits out array drain, then streams the finished C tile to writeback.
module block_mult_sched
    import block_mult_sched_pkg::*;
#(
    parameter int unsigned TILE      = TILE_DEF,
    parameter int unsigned NB_W      = NB_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DRAIN_CYC = 2 * TILE - 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NB_W-1:0]   nblk,
    output logic              busy,
    output logic              done,
    output logic [TILE-1:0]   acc_clear,
    block_mult_sched_if.master mem
);

    localparam int unsigned BEAT_W  = $clog2(TILE);
    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [BEAT_W-1:0]  LastBeat  = BEAT_W'(TILE - 1);
    localparam logic [DRAIN_W-1:0] LastDrain = DRAIN_W'(DRAIN_CYC - 1);

    state_e             state_q, state_d;
    logic [NB_W-1:0]    nblk_q, nblk_d;
    logic [NB_W-1:0]    i_q, i_d;
    logic [NB_W-1:0]    j_q, j_d;
    logic [NB_W-1:0]    k_q, k_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [TILE-1:0]    acc_q;
    logic               load_clear;
    logic [NB_W-1:0]    last_blk;

    logic [ADDR_W-1:0]  a_raw, b_raw, c_raw;

    assign last_blk = nblk_q - NB_W'(1);

    always_comb begin
        state_d    = state_q;
        nblk_d     = nblk_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        load_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (nblk != '0) begin
                        nblk_d  = nblk;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        beat_d  = '0;
                        state_d = StFeed;
                    end else begin
                        state_d = StFin;
                    end
                end
            end

            StFeed: begin
                if (mem.rd_ready) begin
                    // First accepted beat of a new (i, j) tile starts the clear wave.
                    if (beat_q == '0 && k_q == '0) begin
                        load_clear = 1'b1;
                    end
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (k_q != last_blk) begin
                            k_d = k_q + NB_W'(1);
                        end else begin
                            k_d     = '0;
                            drain_d = '0;
                            state_d = StDrain;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            StDrain: begin
                if (drain_q == LastDrain) begin
                    drain_d = '0;
                    beat_d  = '0;
                    state_d = StWrite;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            StWrite: begin
                if (mem.out_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StFeed;
                        if (j_q == last_blk) begin
                            j_d = '0;
                            if (i_q == last_blk) begin
                                i_d     = '0;
                                state_d = StFin;
                            end else begin
                                i_d = i_q + NB_W'(1);
                            end
                        end else begin
                            j_d = j_q + NB_W'(1);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            nblk_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            beat_q  <= '0;
            drain_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            nblk_q  <= nblk_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            // Shifts every clock so the skew stays aligned with the array even under stalls.
            acc_q   <= {acc_q[TILE-2:0], load_clear};
        end
    end

    block_addr_gen #(
        .TILE   (TILE),
        .NB_W   (NB_W),
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W)
    ) u_addr_gen (
        .i_i      (i_q),
        .j_i      (j_q),
        .k_i      (k_q),
        .nblk_i   (nblk_q),
        .beat_i   (beat_q),
        .row_i    (beat_q),
        .a_addr_o (a_raw),
        .b_addr_o (b_raw),
        .c_addr_o (c_raw)
    );

    // All outputs decode from registered state only; ready never reaches them combinationally.
    assign mem.rd_valid  = (state_q == StFeed);
    assign mem.out_valid = (state_q == StWrite);
    assign mem.a_addr    = mem.rd_valid ? a_raw : '0;
    assign mem.b_addr    = mem.rd_valid ? b_raw : '0;
    assign mem.c_addr    = mem.out_valid ? c_raw : '0;
    assign busy          = (state_q == StFeed) || (state_q == StDrain) || (state_q == StWrite);
    assign done          = (state_q == StFin);
    assign acc_clear     = acc_q;

endmodule

// File: tb/tb_block_mult_sched.sv
// Directed bench for block_mult_sched: cycle-exact timing checks plus an address scoreboard.
module tb_block_mult_sched;

    localparam int unsigned TILE      = 4;
    localparam int unsigned NB_W      = 4;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DRAIN_CYC = 7;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [NB_W-1:0] nblk  = '0;
    logic            busy;
    logic            done;
    logic [TILE-1:0] acc_clear;

    block_mult_sched_if #(.ADDR_W(ADDR_W)) mem ();

    block_mult_sched #(
        .TILE      (TILE),
        .NB_W      (NB_W),
        .ADDR_W    (ADDR_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .nblk      (nblk),
        .busy      (busy),
        .done      (done),
        .acc_clear (acc_clear),
        .mem       (mem)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned a;
        int unsigned b;
    } rd_t;

    rd_t         exp_rd[$];
    int unsigned exp_c[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_reads(input int unsigned i, input int unsigned j, input int unsigned nb);
        rd_t e;
        for (int unsigned k = 0; k < nb; k++) begin
            for (int unsigned r = 0; r < TILE; r++) begin
                e.a = ((i * nb + k) * TILE + r) % (1 << ADDR_W);
                e.b = ((k * nb + j) * TILE + r) % (1 << ADDR_W);
                exp_rd.push_back(e);
            end
        end
    endtask

    task automatic push_writes(input int unsigned i, input int unsigned j, input int unsigned nb);
        for (int unsigned r = 0; r < TILE; r++) begin
            exp_c.push_back(((i * nb + j) * TILE + r) % (1 << ADDR_W));
        end
    endtask

    // Scoreboard: every accepted read or writeback beat pops the next expected address.
    always @(negedge clock) begin
        rd_t         e;
        int unsigned c;
        if (reset && mem.rd_valid && mem.rd_ready) begin
            check("rd_pending", 32'(exp_rd.size() > 0), 32'd1);
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                check("sb_a_addr", 32'(mem.a_addr), e.a);
                check("sb_b_addr", 32'(mem.b_addr), e.b);
            end
        end
        if (reset && mem.out_valid && mem.out_ready) begin
            check("wr_pending", 32'(exp_c.size() > 0), 32'd1);
            if (exp_c.size() > 0) begin
                c = exp_c.pop_front();
                check("sb_c_addr", 32'(mem.c_addr), c);
            end
        end
    end

    // nblk=1 run starting now (cycle 0), with an optional rd_ready stall and out_ready toggling.
    task automatic run_one(input string tag, input int stall_at, input int stall_len,
                           input bit toggle);
        int feed_end;
        int ws;
        int done_c;
        int beat;
        int row;
        feed_end = 4 + stall_len;
        ws       = feed_end + 8;
        done_c   = toggle ? ws + 7 : ws + 4;
        push_reads(0, 0, 1);
        push_writes(0, 0, 1);
        start         = 1'b1;
        nblk          = NB_W'(1);
        mem.rd_ready  = 1'b1;
        mem.out_ready = 1'b1;
        step();
        for (int c = 1; c <= done_c + 1; c++) begin
            // A stray start mid-run must be ignored.
            start         = (c == 6);
            nblk          = (c == 6) ? NB_W'(3) : NB_W'(1);
            mem.rd_ready  = !(c >= stall_at && c < stall_at + stall_len);
            mem.out_ready = !toggle || (c < ws) || (((c - ws) % 2) == 0);
            check({tag, "_rd_valid"}, 32'(mem.rd_valid), 32'(c >= 1 && c <= feed_end));
            check({tag, "_out_valid"}, 32'(mem.out_valid), 32'(c >= ws && c < done_c));
            check({tag, "_busy"}, 32'(busy), 32'(c >= 1 && c < done_c));
            check({tag, "_done"}, 32'(done), 32'(c == done_c));
            check({tag, "_acc_clear"}, 32'(acc_clear),
                  (c >= 2 && c <= 5) ? (32'd1 << (c - 2)) : 32'd0);
            if (c <= feed_end) begin
                if (c < stall_at || stall_len == 0) beat = c - 1;
                else if (c - stall_at < stall_len) beat = stall_at - 1;
                else beat = c - 1 - stall_len;
                check({tag, "_a_addr"}, 32'(mem.a_addr), 32'(beat));
                check({tag, "_b_addr"}, 32'(mem.b_addr), 32'(beat));
            end
            if (c >= ws && c < done_c) begin
                row = toggle ? (c - ws + 1) / 2 : c - ws;
                check({tag, "_c_addr"}, 32'(mem.c_addr), 32'(row));
            end
            step();
        end
        start = 1'b0;
        nblk  = NB_W'(1);
    endtask

    initial begin
        int fires;
        int done_at;
        int cyc;

        mem.rd_ready  = 1'b1;
        mem.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(mem.rd_valid), 32'd0);
        check("rst_out_valid", 32'(mem.out_valid), 32'd0);
        check("rst_acc_clear", 32'(acc_clear), 32'd0);
        check("rst_a_addr", 32'(mem.a_addr), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Scenario 1: nblk=1, ready high
        run_one("s1", 0, 0, 1'b0);

        // Scenario 2: nblk=2, four tiles
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < 2; j++) begin
                push_reads(i, j, 2);
                push_writes(i, j, 2);
            end
        end
        start = 1'b1;
        nblk  = NB_W'(2);
        step();
        start   = 1'b0;
        cyc     = 1;
        fires   = 0;
        done_at = -1;
        for (int n = 0; n < 300; n++) begin
            if (acc_clear[0]) fires++;
            if (done) begin
                done_at = cyc;
                break;
            end
            step();
            cyc++;
        end
        check("s2_done_cycle", 32'(done_at), 32'd77);
        check("s2_clear_fires", 32'(fires), 32'd4);
        check("s2_rd_drained", 32'(exp_rd.size()), 32'd0);
        check("s2_wr_drained", 32'(exp_c.size()), 32'd0);
        step();

        // Scenario 3: rd_ready low for 3 cycles at beat 2
        run_one("s3", 3, 3, 1'b0);

        // Scenario 4: out_ready toggling during writeback
        run_one("s4", 0, 0, 1'b1);

        // Scenario 5: nblk=0 goes straight to FIN
        start = 1'b1;
        nblk  = NB_W'(0);
        step();
        start = 1'b0;
        check("s5_done", 32'(done), 32'd1);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_rd_valid", 32'(mem.rd_valid), 32'd0);
        check("s5_out_valid", 32'(mem.out_valid), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            step();
            check("s5_done_after", 32'(done), 32'd0);
            check("s5_rd_valid_after", 32'(mem.rd_valid), 32'd0);
            check("s5_out_valid_after", 32'(mem.out_valid), 32'd0);
        end

        // Scenario 6: asynchronous reset in DRAIN, then a clean rerun
        push_reads(0, 0, 1);
        start = 1'b1;
        nblk  = NB_W'(1);
        step();
        start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        check("s6_in_drain_busy", 32'(busy), 32'd1);
        check("s6_in_drain_rd_valid", 32'(mem.rd_valid), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        check("s6_rst_rd_valid", 32'(mem.rd_valid), 32'd0);
        check("s6_rst_out_valid", 32'(mem.out_valid), 32'd0);
        check("s6_rst_acc_clear", 32'(acc_clear), 32'd0);
        check("s6_rst_addrs", 32'(mem.a_addr | mem.b_addr | mem.c_addr), 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("s6_no_done", 32'(done), 32'd0);
            check("s6_idle_busy", 32'(busy), 32'd0);
            step();
        end
        run_one("s6", 0, 0, 1'b0);

        check("end_rd_drained", 32'(exp_rd.size()), 32'd0);
        check("end_wr_drained", 32'(exp_c.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
